// File: rtl/adder_carry_resolve.sv
// Final sum stage of the prefix adder: registered Kogge-Stone carry tree, one level per cycle.
// Latency: $clog2(DATA_W)+1 cycles from input transfer to out_valid; throughput 1 op/cycle.
// Backpressure: in_ready = !out_valid | out_ready; when low the whole pipe, bubbles included, holds.
module adder_carry_resolve #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] gen_in,
  input  logic [DATA_W-1:0] prop_in,
  input  logic              cin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int LOG2_W = $clog2(DATA_W);

  // Stage s holds (G, P) after s prefix levels; stage 0 has cin folded into bit 0.
  logic [DATA_W-1:0] g_q  [LOG2_W+1];
  logic [DATA_W-1:0] p_q  [LOG2_W+1];
  logic [DATA_W-1:0] po_q [LOG2_W+1];
  logic              ci_q [LOG2_W+1];
  logic              v_q  [LOG2_W+1];

  logic [DATA_W-1:0] g_nx [LOG2_W+1];
  logic [DATA_W-1:0] p_nx [LOG2_W+1];

  logic              en;
  logic [DATA_W-1:0] g_fin;
  logic [DATA_W-1:0] carries;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign g_nx[0] = {gen_in[DATA_W-1:1], gen_in[0] | (prop_in[0] & cin)};
  assign p_nx[0] = prop_in;

  for (genvar k = 1; k <= LOG2_W; k++) begin : g_level
    localparam int D = 1 << (k - 1);
    // Bits below the span keep their P unchanged rather than being masked to zero.
    localparam logic [DATA_W-1:0] LOW = (DATA_W'(1) << D) - DATA_W'(1);
    assign g_nx[k] = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << D));
    assign p_nx[k] = p_q[k-1] & ((p_q[k-1] << D) | LOW);
  end

  assign g_fin   = g_q[LOG2_W];
  assign carries = {g_fin[DATA_W-2:0], ci_q[LOG2_W]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= LOG2_W; s++) begin
        v_q[s]  <= 1'b0;
        g_q[s]  <= '0;
        p_q[s]  <= '0;
        po_q[s] <= '0;
        ci_q[s] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      v_q[0]  <= in_valid;
      g_q[0]  <= g_nx[0];
      p_q[0]  <= p_nx[0];
      po_q[0] <= prop_in;
      ci_q[0] <= cin;
      for (int s = 1; s <= LOG2_W; s++) begin
        v_q[s]  <= v_q[s-1];
        g_q[s]  <= g_nx[s];
        p_q[s]  <= p_nx[s];
        po_q[s] <= po_q[s-1];
        ci_q[s] <= ci_q[s-1];
      end
      out_valid <= v_q[LOG2_W];
      sum       <= po_q[LOG2_W] ^ carries;
      cout      <= g_fin[DATA_W-1];
      ovf       <= g_fin[DATA_W-1] ^ g_fin[DATA_W-2];
    end
  end

endmodule

// File: tb/tb_adder_carry_resolve.sv
// Directed and table-driven checks of adder_carry_resolve against an A+B+cin reference.
module tb_adder_carry_resolve;

  localparam int W   = 32;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gen_in, prop_in;
  logic         cin, in_valid, in_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, out_valid, out_ready;

  adder_carry_resolve #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .gen_in(gen_in), .prop_in(prop_in), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rx    = 0;
  int   tx    = 0;
  bit   chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every output transfer is checked in order against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        rx++;
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("sum",  64'(sum),  64'(e.s));
          chk("cout", 64'(cout), 64'(e.co));
          chk("ovf",  64'(ovf),  64'(e.ov));
          if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'(LAT));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic [W-1:0] es, input logic eco, input logic eov);
    exp_t e;
    bit   done = 1'b0;
    gen_in   = a & b;
    prop_in  = a ^ b;
    cin      = ci;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e.s = es; e.co = eco; e.ov = eov; e.acc = cyc + 1;
        q.push_back(e);
        tx++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    send(a, b, ci, full[W-1:0], full[W], v);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  vec_t vecs[8];
  int   rx0;
  logic [W-1:0] held;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    // Reset held three cycles with in_valid asserted.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    gen_in = 32'h0000_00F0; prop_in = 32'h0000_000F; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_cout",      64'(cout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Hand-computed vectors, one at a time, with exact latency.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ov);
      drain();
    end

    // Back-to-back stream, one result per cycle.
    for (int i = 0; i < 64; i++) send_model($urandom, $urandom, 1'($urandom_range(0, 1)));
    drain();
    chk("b2b_count", 64'(rx), 64'(tx));

    // Backpressure mid-stream.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_model($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (i == 0) begin
            held = sum;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
          end
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_sum_held", 64'(sum), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(rx), 64'(tx));

    // Reset with three ops in flight: none may emerge.
    for (int i = 0; i < 3; i++) send_model($urandom, $urandom, 1'b0);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx0 = rx;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_no_emit", 64'(rx - rx0), 64'd0);
    chk_lat = 1'b1;
    send_model(32'h0000_FFFF, 32'h0000_0001, 1'b1);
    drain();
    chk("post_rst_count", 64'(rx - rx0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
